// File: rtl/tb_ctrl_pkg.sv
// Shared types for the end-of-test controller: state encoding, status bundle
// and the cycle-counter width helper.
package tb_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_END   = 2'd3;

  typedef struct packed {
    logic pass;
    logic fail;
    logic timeout;
  } status_t;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at MAX instead of wrapping.
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/test_end_ctrl.sv
// Collects agent done/err pulses, runs a watchdog and a drain period, then
// raises a single end-of-test request with pass/fail status.
//
// state    | meaning
// IDLE     | waiting for start after reset
// RUN      | counting cycles, collecting done/err pulses
// DRAIN    | all agents done, waiting DRAIN_CYCLES before ending
// END      | status held, end_req pulsed on entry; start re-arms
module test_end_ctrl
  import tb_ctrl_pkg::*;
#(
  parameter int NUM_AGENTS     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DRAIN_CYCLES   = 4,
  parameter int CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_AGENTS-1:0] agent_done,
  input  logic [NUM_AGENTS-1:0] agent_err,
  output logic                  busy,
  output logic [NUM_AGENTS-1:0] done_mask,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  end_req,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout
);

  localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int DW         = (DRAIN_LOAD > 0) ? $clog2(DRAIN_LOAD + 1) : 1;

  state_t                  state;
  state_t                  state_nx;
  status_t                 status;
  status_t                 status_nx;
  logic                    err_seen;
  logic                    err_nx;
  logic [DW-1:0]           drain_cnt;
  logic [NUM_AGENTS-1:0]   done_now;
  logic                    all_done;
  logic                    at_limit;
  logic                    timeout_hit;
  logic                    clear_run;
  logic                    count_en;
  logic                    entering_end;

  assign done_now  = done_mask | agent_done;
  assign all_done  = &done_now;
  assign at_limit  = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign clear_run = start && ((state == ST_IDLE) || (state == ST_END));
  // Counter freezes on the cycle RUN is left, so it reports the exit cycle.
  assign count_en  = (state == ST_RUN) && !all_done && !at_limit;

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    err_nx      = err_seen | (|agent_err);
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN: begin
        if (all_done) begin
          state_nx = (DRAIN_CYCLES == 0) ? ST_END : ST_DRAIN;
        end else if (at_limit) begin
          state_nx    = ST_END;
          timeout_hit = 1'b1;
        end
      end
      ST_DRAIN: if (drain_cnt == '0) state_nx = ST_END;
      ST_END:   if (start) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign entering_end      = (state_nx == ST_END) && (state != ST_END);
  assign status_nx.timeout = timeout_hit;
  assign status_nx.pass    = !err_nx && !timeout_hit;
  assign status_nx.fail    = err_nx || timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      end_req   <= 1'b0;
      status    <= '0;
      done_mask <= '0;
      err_seen  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
      end_req <= entering_end;
      if (entering_end) begin
        status <= status_nx;
      end else if (clear_run) begin
        status <= '0;
      end
      case (state)
        ST_IDLE, ST_END: begin
          if (start) begin
            done_mask <= '0;
            err_seen  <= 1'b0;
          end
        end
        ST_RUN: begin
          done_mask <= done_now;
          err_seen  <= err_nx;
          drain_cnt <= DW'(DRAIN_LOAD);
        end
        ST_DRAIN: begin
          err_seen <= err_nx;
          if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX (TIMEOUT_CYCLES)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_run),
    .en    (count_en),
    .count (cycle_count)
  );

  assign pass    = status.pass;
  assign fail    = status.fail;
  assign timeout = status.timeout;

endmodule

// File: tb/tb_test_end_ctrl.sv
// Directed bench for test_end_ctrl: a DRAIN=4 instance and a DRAIN=0 instance,
// both with two agents and a 20-cycle watchdog.
module tb_test_end_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DRAIN_CYCLES=4
  logic       rst_n, start;
  logic [1:0] agent_done, agent_err, done_mask;
  logic [4:0] cycle_count;
  logic       busy, end_req, pass, fail, timeout;

  // Instance B: DRAIN_CYCLES=0
  logic       rst_n_b, start_b;
  logic [1:0] agent_done_b, agent_err_b, done_mask_b;
  logic [4:0] cycle_count_b;
  logic       busy_b, end_req_b, pass_b, fail_b, timeout_b;

  test_end_ctrl #(.NUM_AGENTS(2), .TIMEOUT_CYCLES(20), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .agent_done(agent_done),
    .agent_err(agent_err), .busy(busy), .done_mask(done_mask),
    .cycle_count(cycle_count), .end_req(end_req), .pass(pass), .fail(fail),
    .timeout(timeout));

  test_end_ctrl #(.NUM_AGENTS(2), .TIMEOUT_CYCLES(20), .DRAIN_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .agent_done(agent_done_b),
    .agent_err(agent_err_b), .busy(busy_b), .done_mask(done_mask_b),
    .cycle_count(cycle_count_b), .end_req(end_req_b), .pass(pass_b), .fail(fail_b),
    .timeout(timeout_b));

  typedef struct {
    logic       st;
    logic [1:0] dn;
    logic [1:0] er;
    logic       busy;
    logic       ereq;
    logic       pass;
    logic       fail;
    logic       to;
    logic [1:0] mask;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic st, input logic [1:0] dn, input logic [1:0] er);
    start = st; agent_done = dn; agent_err = er;
    tick();
    start = 1'b0; agent_done = 2'b00; agent_err = 2'b00;
  endtask

  task automatic cyc_b(input logic st, input logic [1:0] dn);
    start_b = st; agent_done_b = dn; agent_err_b = 2'b00;
    tick();
    start_b = 1'b0; agent_done_b = 2'b00;
  endtask

  task automatic chk_status(input string tag, input logic ereq, input logic p,
                            input logic f, input logic t, input int mask, input int cnt);
    chk({tag, " end_req"}, int'(end_req), int'(ereq));
    chk({tag, " pass"}, int'(pass), int'(p));
    chk({tag, " fail"}, int'(fail), int'(f));
    chk({tag, " timeout"}, int'(timeout), int'(t));
    chk({tag, " done_mask"}, int'(done_mask), mask);
    chk({tag, " cycle_count"}, int'(cycle_count), cnt);
  endtask

  initial begin
    // st dn er | busy ereq pass fail to mask cnt
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd2};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd3};
    vecs[4]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd4};
    vecs[5]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd5};
    vecs[6]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd6};
    vecs[7]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd7};
    vecs[8]  = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd7};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd7};
    vecs[10] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd7};
    vecs[11] = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'd7};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 5'd7};
    vecs[13] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 5'd7};

    rst_n = 1'b0; start = 1'b0; agent_done = 2'b00; agent_err = 2'b00;
    rst_n_b = 1'b0; start_b = 1'b0; agent_done_b = 2'b00; agent_err_b = 2'b00;
    tick(); tick();
    chk("reset busy", int'(busy), 0);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("reset b busy", int'(busy_b), 0);
    rst_n = 1'b1; rst_n_b = 1'b1;
    cyc(1'b0, 2'b00, 2'b00);
    chk("idle busy", int'(busy), 0);

    // Test 1: normal pass with drain, via vector table
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].st, vecs[i].dn, vecs[i].er);
      chk($sformatf("t1[%0d] busy", i), int'(busy), int'(vecs[i].busy));
      chk_status($sformatf("t1[%0d]", i), vecs[i].ereq, vecs[i].pass, vecs[i].fail,
                 vecs[i].to, int'(vecs[i].mask), int'(vecs[i].cnt));
    end

    // Test 2: watchdog timeout, only agent 0 done
    cyc(1'b1, 2'b00, 2'b00);
    chk("t2 start clears pass", int'(pass), 0);
    cyc(1'b0, 2'b01, 2'b00);
    for (int i = 2; i < 20; i++) cyc(1'b0, 2'b00, 2'b00);
    chk("t2 pre-timeout busy", int'(busy), 1);
    chk("t2 pre-timeout end_req", int'(end_req), 0);
    cyc(1'b0, 2'b00, 2'b00);
    chk("t2 busy", int'(busy), 0);
    chk_status("t2", 1'b1, 1'b0, 1'b1, 1'b1, 1, 19);
    cyc(1'b0, 2'b00, 2'b00);
    chk_status("t2 hold", 1'b0, 1'b0, 1'b1, 1'b1, 1, 19);

    // Test 3: error pulse during drain
    cyc(1'b1, 2'b00, 2'b00);
    chk_status("t3 restart", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 2'b00, 2'b00);
    cyc(1'b0, 2'b00, 2'b00);
    cyc(1'b0, 2'b11, 2'b00);
    cyc(1'b0, 2'b00, 2'b00);
    cyc(1'b0, 2'b00, 2'b10);
    cyc(1'b0, 2'b00, 2'b00);
    chk("t3 drain busy", int'(busy), 1);
    cyc(1'b0, 2'b00, 2'b00);
    chk_status("t3", 1'b1, 1'b0, 1'b1, 1'b0, 3, 2);

    // Test 4: last done coincides with the timeout cycle
    cyc(1'b1, 2'b00, 2'b00);
    cyc(1'b0, 2'b01, 2'b00);
    for (int i = 2; i < 20; i++) cyc(1'b0, 2'b00, 2'b00);
    cyc(1'b0, 2'b10, 2'b00);
    chk("t4 drain busy", int'(busy), 1);
    chk("t4 no end_req", int'(end_req), 0);
    chk("t4 cnt frozen", int'(cycle_count), 19);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 2'b00);
    chk("t4 drain end_req", int'(end_req), 0);
    cyc(1'b0, 2'b00, 2'b00);
    chk_status("t4", 1'b1, 1'b1, 1'b0, 1'b0, 3, 19);

    // Test 5: reset mid-drain aborts, then a clean run
    cyc(1'b1, 2'b00, 2'b00);
    cyc(1'b0, 2'b11, 2'b00);
    cyc(1'b0, 2'b00, 2'b00);
    rst_n = 1'b0;
    cyc(1'b0, 2'b00, 2'b00);
    rst_n = 1'b1;
    chk("t5 rst busy", int'(busy), 0);
    chk_status("t5 rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'b00, 2'b00);
      chk($sformatf("t5 idle[%0d] end_req", i), int'(end_req), 0);
    end
    cyc(1'b1, 2'b00, 2'b00);
    cyc(1'b0, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 2'b00);
    chk("t5 drain end_req", int'(end_req), 0);
    cyc(1'b0, 2'b00, 2'b00);
    chk_status("t5", 1'b1, 1'b1, 1'b0, 1'b0, 3, 0);

    // Test 6: DRAIN_CYCLES=0 build, start ignored in RUN, restart from END
    cyc_b(1'b1, 2'b00);
    cyc_b(1'b0, 2'b00);
    cyc_b(1'b1, 2'b00);
    cyc_b(1'b0, 2'b00);
    chk("t6 cnt after start in RUN", int'(cycle_count_b), 3);
    chk("t6 busy in RUN", int'(busy_b), 1);
    cyc_b(1'b0, 2'b00);
    cyc_b(1'b0, 2'b00);
    cyc_b(1'b0, 2'b11);
    chk("t6 end_req", int'(end_req_b), 1);
    chk("t6 busy", int'(busy_b), 0);
    chk("t6 pass", int'(pass_b), 1);
    chk("t6 fail", int'(fail_b), 0);
    chk("t6 cnt", int'(cycle_count_b), 5);
    chk("t6 mask", int'(done_mask_b), 3);
    cyc_b(1'b1, 2'b00);
    chk("t6 restart busy", int'(busy_b), 1);
    chk("t6 restart end_req", int'(end_req_b), 0);
    chk("t6 restart pass", int'(pass_b), 0);
    chk("t6 restart fail", int'(fail_b), 0);
    chk("t6 restart mask", int'(done_mask_b), 0);
    chk("t6 restart cnt", int'(cycle_count_b), 0);
    cyc_b(1'b0, 2'b11);
    chk("t6 second end_req", int'(end_req_b), 1);
    chk("t6 second cnt", int'(cycle_count_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
